// File: rtl/tc_dot_reduce.sv
// Dot-product reduction: pipelined binary adder tree over SHAPE_K product lanes,
// then accumulate with C and saturate to ACC_WIDTH. Sideband rides alongside each beat.
module tc_dot_reduce #(
  parameter int SHAPE_K       = 8,
  parameter int ELEMENT_WIDTH = 9,
  parameter int ACC_WIDTH     = 16,
  parameter int CTRL_C_WIDTH  = 16,
  parameter int DEPTH_WARP    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [SHAPE_K*ELEMENT_WIDTH-1:0] prod_i,
  input  logic [4:0]                       fflags_i,
  input  logic [ACC_WIDTH-1:0]             c_i,
  input  logic [CTRL_C_WIDTH-1:0]          ctrl_c_i,
  input  logic [2:0]                       ctrl_rm_i,
  input  logic [7:0]                       ctrl_reg_idxw_i,
  input  logic [DEPTH_WARP-1:0]            ctrl_warpid_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [ACC_WIDTH-1:0]             result_o,
  output logic [4:0]                       fflags_o,
  output logic [CTRL_C_WIDTH-1:0]          ctrl_c_o,
  output logic [2:0]                       ctrl_rm_o,
  output logic [7:0]                       ctrl_reg_idxw_o,
  output logic [DEPTH_WARP-1:0]            ctrl_warpid_o
);

  localparam int LOG2K = $clog2(SHAPE_K);
  localparam int TW    = ELEMENT_WIDTH + LOG2K;
  localparam int FW    = ((TW > ACC_WIDTH) ? TW : ACC_WIDTH) + 1;
  localparam int SW    = 5 + ACC_WIDTH + CTRL_C_WIDTH + 3 + 8 + DEPTH_WARP;

  localparam logic signed [FW-1:0] SAT_MAX = {{(FW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [FW-1:0] SAT_MIN = {{(FW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

  logic                 en;
  logic [LOG2K:1]       vld_q;
  logic [SW-1:0]        side_q [1:LOG2K];
  logic [SW-1:0]        side_d;
  logic [TW-1:0]        leaf [0:SHAPE_K-1];
  // Heap-ordered tree: node i sums children 2i and 2i+1; nodes >= SHAPE_K/2 take leaves.
  logic [TW-1:0]        node_q [1:SHAPE_K-1];

  logic [4:0]              ff_l;
  logic [ACC_WIDTH-1:0]    c_l;
  logic [CTRL_C_WIDTH-1:0] cc_l;
  logic [2:0]              rm_l;
  logic [7:0]              idx_l;
  logic [DEPTH_WARP-1:0]   wid_l;

  logic signed [FW-1:0]  tree_ext, c_ext, full;
  logic                  sat_pos, sat_neg, sat;
  logic [ACC_WIDTH-1:0]  result_d;
  logic [4:0]            fflags_d;

  logic                    out_valid_q;
  logic [ACC_WIDTH-1:0]    result_q;
  logic [4:0]              fflags_q;
  logic [CTRL_C_WIDTH-1:0] ctrl_c_q;
  logic [2:0]              ctrl_rm_q;
  logic [7:0]              ctrl_reg_idxw_q;
  logic [DEPTH_WARP-1:0]   ctrl_warpid_q;

  assign en         = ~out_valid_q | out_ready_i;
  assign in_ready_o = en;
  assign side_d     = {fflags_i, c_i, ctrl_c_i, ctrl_rm_i, ctrl_reg_idxw_i, ctrl_warpid_i};

  always_comb begin
    for (int j = 0; j < SHAPE_K; j++) begin
      leaf[j] = {{LOG2K{prod_i[j*ELEMENT_WIDTH+ELEMENT_WIDTH-1]}}, prod_i[j*ELEMENT_WIDTH +: ELEMENT_WIDTH]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 1; i <= LOG2K; i++) side_q[i] <= '0;
      for (int i = 1; i < SHAPE_K; i++) node_q[i] <= '0;
    end else if (en) begin
      vld_q[1]  <= in_valid_i;
      side_q[1] <= side_d;
      for (int i = 2; i <= LOG2K; i++) begin
        vld_q[i]  <= vld_q[i-1];
        side_q[i] <= side_q[i-1];
      end
      for (int i = SHAPE_K/2; i < SHAPE_K; i++) begin
        node_q[i] <= leaf[2*i-SHAPE_K] + leaf[2*i-SHAPE_K+1];
      end
      for (int i = 1; i < SHAPE_K/2; i++) begin
        node_q[i] <= node_q[2*i] + node_q[2*i+1];
      end
    end
  end

  assign {ff_l, c_l, cc_l, rm_l, idx_l, wid_l} = side_q[LOG2K];

  always_comb begin
    tree_ext = {{(FW-TW){node_q[1][TW-1]}}, node_q[1]};
    c_ext    = {{(FW-ACC_WIDTH){c_l[ACC_WIDTH-1]}}, c_l};
    full     = tree_ext + c_ext;
    sat_pos  = full > SAT_MAX;
    sat_neg  = full < SAT_MIN;
    sat      = sat_pos | sat_neg;
    result_d = full[ACC_WIDTH-1:0];
    if (sat_pos) result_d = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    if (sat_neg) result_d = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    fflags_d = ff_l | {2'b00, sat, 1'b0, sat};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      result_q        <= '0;
      fflags_q        <= '0;
      ctrl_c_q        <= '0;
      ctrl_rm_q       <= '0;
      ctrl_reg_idxw_q <= '0;
      ctrl_warpid_q   <= '0;
    end else if (en) begin
      out_valid_q <= vld_q[LOG2K];
      // Data only moves on real beats so bubbles leave the last result visible.
      if (vld_q[LOG2K]) begin
        result_q        <= result_d;
        fflags_q        <= fflags_d;
        ctrl_c_q        <= cc_l;
        ctrl_rm_q       <= rm_l;
        ctrl_reg_idxw_q <= idx_l;
        ctrl_warpid_q   <= wid_l;
      end
    end
  end

  assign out_valid_o     = out_valid_q;
  assign result_o        = result_q;
  assign fflags_o        = fflags_q;
  assign ctrl_c_o        = ctrl_c_q;
  assign ctrl_rm_o       = ctrl_rm_q;
  assign ctrl_reg_idxw_o = ctrl_reg_idxw_q;
  assign ctrl_warpid_o   = ctrl_warpid_q;

endmodule

// File: tb/tb_tc_dot_reduce.sv
// Scoreboard bench for tc_dot_reduce: driver pushes expected results at accept,
// an independent monitor pops and compares on every output transfer.
module tb_tc_dot_reduce;
  localparam int K  = 8;
  localparam int EW = 9;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [K*EW-1:0] prod_i;
  logic [4:0]    fflags_i;
  logic [AW-1:0] c_i;
  logic [15:0]   ctrl_c_i;
  logic [2:0]    ctrl_rm_i;
  logic [7:0]    ctrl_reg_idxw_i;
  logic [3:0]    ctrl_warpid_i;
  logic          in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [AW-1:0] result_o;
  logic [4:0]    fflags_o;
  logic [15:0]   ctrl_c_o;
  logic [2:0]    ctrl_rm_o;
  logic [7:0]    ctrl_reg_idxw_o;
  logic [3:0]    ctrl_warpid_o;

  tc_dot_reduce dut (
    .clk(clk), .rst(rst), .prod_i(prod_i), .fflags_i(fflags_i), .c_i(c_i),
    .ctrl_c_i(ctrl_c_i), .ctrl_rm_i(ctrl_rm_i), .ctrl_reg_idxw_i(ctrl_reg_idxw_i),
    .ctrl_warpid_i(ctrl_warpid_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .fflags_o(fflags_o), .ctrl_c_o(ctrl_c_o), .ctrl_rm_o(ctrl_rm_o),
    .ctrl_reg_idxw_o(ctrl_reg_idxw_o), .ctrl_warpid_o(ctrl_warpid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  ff;
    logic [15:0] cc;
    logic [2:0]  rm;
    logic [7:0]  idx;
    logic [3:0]  wid;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stall_lo = -1, stall_hi = -1;
  bit   lat_chk = 1'b1;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer dot product, then clamp to the signed 16-bit range.
  function automatic void model(input logic [K*EW-1:0] p, input logic [15:0] c,
                                input logic [4:0] ff, output logic [15:0] res,
                                output logic [4:0] ffo);
    int s;
    s = $signed(c);
    for (int j = 0; j < K; j++) s += $signed(p[j*EW +: EW]);
    ffo = ff;
    if (s > 32767) begin
      res = 16'h7FFF; ffo = ff | 5'b00101;
    end else if (s < -32768) begin
      res = 16'h8000; ffo = ff | 5'b00101;
    end else begin
      res = s[15:0];
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rand_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
    else          out_ready_i = !(cyc >= stall_lo && cyc < stall_hi);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      in_valid_i = 1'b0;
    end
  endtask

  task automatic send(input logic [K*EW-1:0] p, input logic [15:0] c, input logic [4:0] ff,
                      input logic [3:0] wid, input bit use_exp,
                      input logic [15:0] eres, input logic [4:0] eff);
    exp_t e;
    int   n = 0;
    logic [15:0] cc  = 16'($urandom);
    logic [2:0]  rm  = 3'($urandom);
    logic [7:0]  idx = 8'($urandom);
    forever begin
      tick();
      prod_i = p; c_i = c; fflags_i = ff; ctrl_c_i = cc; ctrl_rm_i = rm;
      ctrl_reg_idxw_i = idx; ctrl_warpid_i = wid; in_valid_i = 1'b1;
      #1;
      if (in_ready_o) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 32'(n), 32'd0);
        return;
      end
    end
    if (use_exp) begin
      e.res = eres; e.ff = eff;
    end else begin
      model(p, c, ff, e.res, e.ff);
    end
    e.cc = cc; e.rm = rm; e.idx = idx; e.wid = wid;
    e.acc_cyc = cyc; e.lat = lat_chk;
    sb.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    bit   prev_stall = 1'b0;
    logic [15:0] prev_res;
    logic [3:0]  prev_wid;
    forever begin
      @(negedge clk);
      #1;
      if (prev_stall && out_valid_o) begin
        chk("hold_result", 32'(result_o), 32'(prev_res));
        chk("hold_warpid", 32'(ctrl_warpid_o), 32'(prev_wid));
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_res   = result_o;
      prev_wid   = ctrl_warpid_o;
      if (out_valid_o && !out_ready_i) chk("in_ready_stalled", 32'(in_ready_o), 32'd0);
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(result_o), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("result", 32'(result_o), 32'(e.res));
          chk("fflags", 32'(fflags_o), 32'(e.ff));
          chk("ctrl_c", 32'(ctrl_c_o), 32'(e.cc));
          chk("ctrl_rm", 32'(ctrl_rm_o), 32'(e.rm));
          chk("ctrl_idxw", 32'(ctrl_reg_idxw_o), 32'(e.idx));
          chk("ctrl_warpid", 32'(ctrl_warpid_o), 32'(e.wid));
          if (e.lat) chk("latency", 32'(cyc - e.acc_cyc), 32'd4);
        end
      end
    end
  end

  initial begin
    logic [K*EW-1:0] p;
    logic [K*EW-1:0] pa;
    int t0;
    rst = 1'b1; prod_i = '0; fflags_i = '0; c_i = '0; ctrl_c_i = '0; ctrl_rm_i = '0;
    ctrl_reg_idxw_i = '0; ctrl_warpid_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_result", 32'(result_o), 32'd0);
    chk("rst_fflags", 32'(fflags_o), 32'd0);
    chk("rst_ctrl", 32'({ctrl_c_o, ctrl_rm_o, ctrl_reg_idxw_o, ctrl_warpid_o}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);

    // Directed vectors with literal expectations
    for (int j = 0; j < K; j++) p[j*EW +: EW] = 9'(j + 1);
    send(p, 16'd100, 5'd0, 4'h5, 1'b1, 16'd136, 5'd0);
    pa = {K{9'h100}};
    send(pa, 16'd0, 5'd0, 4'h1, 1'b1, 16'hF800, 5'd0);
    pa = {K{9'h0FF}};
    send(pa, 16'hF808, 5'd0, 4'h2, 1'b1, 16'h0000, 5'd0);
    pa = {K{9'h001}};
    send(pa, 16'h7FFF, 5'd0, 4'h3, 1'b1, 16'h7FFF, 5'b00101);
    pa = {K{9'h1FF}};
    send(pa, 16'h8000, 5'd0, 4'h4, 1'b1, 16'h8000, 5'b00101);
    send('0, 16'd5, 5'b10000, 4'h6, 1'b1, 16'd5, 5'b10000);
    idle(8);

    // Backpressure window over the output stream
    lat_chk  = 1'b0;
    stall_lo = cyc + 6;
    stall_hi = cyc + 10;
    for (int i = 0; i < 10; i++) send('0, 16'(i), 5'd0, 4'(i), 1'b1, 16'(i), 5'd0);
    idle(15);
    stall_lo = -1; stall_hi = -1;

    // Full-rate random stream
    lat_chk = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < K; j++) p[j*EW +: EW] = 9'($urandom);
      send(p, ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 4000)),
           5'($urandom), 4'($urandom), 1'b0, 16'd0, 5'd0);
    end
    chk("full_rate_cycles", 32'(cyc - t0), 32'd20);
    idle(8);

    // Random backpressure with bubbles
    lat_chk  = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < K; j++) p[j*EW +: EW] = 9'($urandom);
      send(p, 16'($urandom), 5'($urandom), 4'($urandom), 1'b0, 16'd0, 5'd0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_rdy = 1'b0;
    idle(20);

    // Reset with beats in flight
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < K; j++) p[j*EW +: EW] = 9'($urandom);
      send(p, 16'($urandom), 5'd0, 4'($urandom), 1'b0, 16'd0, 5'd0);
    end
    tick();
    in_valid_i = 1'b0;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
    tick();
    rst = 1'b0;
    idle(6);
    for (int j = 0; j < K; j++) p[j*EW +: EW] = 9'(j + 1);
    send(p, 16'd100, 5'd0, 4'h5, 1'b1, 16'd136, 5'd0);

    begin
      int n = 0;
      idle(1);
      while (sb.size() != 0 && n < 100) begin
        idle(1);
        n++;
      end
    end
    idle(6);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
